// File: rtl/tl_pkg.sv
// Shared lamp encodings, fault codes and monitor states for the intersection safety monitor.
// Purely declarative; no logic, no latency, no backpressure.
package tl_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_CLEARANCE = 3'd2,
    FC_ILLEGAL   = 3'd3,
    FC_DARK      = 3'd4
  } fault_code_t;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } mon_state_t;

  function automatic logic is_movement(input logic [2:0] aspect);
    return (aspect == YELLOW) || (aspect == GREEN);
  endfunction

endpackage

// File: rtl/aspect_checker.sv
// Per-light lamp decode, green/release edge detect and armed dark-lamp counter.
// Decode flags are combinational; dark_hit is registered. Never stalls the lamp stream.
module aspect_checker
  import tl_pkg::*;
#(
  parameter int DARK_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ltf,
  output logic       movement,
  output logic       red,
  output logic       illegal,
  output logic       green_rise,
  output logic       mov_to_red,
  output logic       dark_hit
);

  logic [2:0] ltf_q;
  logic       armed;
  logic       dark;
  logic [7:0] dark_cnt;

  always_comb begin
    movement   = is_movement(ltf);
    red        = (ltf == RED);
    dark       = (ltf == DARK);
    illegal    = !movement && !red && !dark;
    green_rise = (ltf == GREEN) && (ltf_q != GREEN);
    mov_to_red = red && is_movement(ltf_q);
    dark_hit   = (dark_cnt == 8'(DARK_LIMIT));
  end

  // A light only becomes subject to dark checking once it has shown any lamp,
  // so the all-dark power-up period is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      ltf_q    <= DARK;
      armed    <= 1'b0;
      dark_cnt <= '0;
    end else begin
      ltf_q <= ltf;
      if (!dark) begin
        armed <= 1'b1;
      end
      if (armed && dark) begin
        if (dark_cnt != 8'(DARK_LIMIT)) begin
          dark_cnt <= dark_cnt + 8'd1;
        end
      end else begin
        dark_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/conflict_monitor.sv
// Safety monitor: conflict/clearance/illegal/dark detection, latched fault with ack + timed all-red recovery.
// Detection is registered one cycle ahead of the FSM; all outputs registered; no backpressure.
module conflict_monitor
  import tl_pkg::*;
#(
  parameter int                           N_LIGHTS     = 4,
  parameter logic [N_LIGHTS*N_LIGHTS-1:0] PERMIT       = 16'h0000,
  parameter int                           DEBOUNCE     = 2,
  parameter int                           CLEAR_CYCLES = 3,
  parameter int                           DARK_LIMIT   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_LIGHTS-1:0][2:0] ltfs,
  input  logic                     ack,
  output logic                     fault,
  output logic [2:0]               fault_code,
  output logic [1:0]               fault_light,
  output logic [N_LIGHTS-1:0]      force_reds,
  output logic [N_LIGHTS-1:0]      attentions
);

  logic [N_LIGHTS-1:0] movement;
  logic [N_LIGHTS-1:0] red;
  logic [N_LIGHTS-1:0] illegal;
  logic [N_LIGHTS-1:0] green_rise;
  logic [N_LIGHTS-1:0] mov_to_red;
  logic [N_LIGHTS-1:0] dark_hit;

  for (genvar gl = 0; gl < N_LIGHTS; gl++) begin : g_light
    aspect_checker #(
      .DARK_LIMIT (DARK_LIMIT)
    ) u_aspect_checker (
      .clk        (clk),
      .rst        (rst),
      .ltf        (ltfs[gl]),
      .movement   (movement[gl]),
      .red        (red[gl]),
      .illegal    (illegal[gl]),
      .green_rise (green_rise[gl]),
      .mov_to_red (mov_to_red[gl]),
      .dark_hit   (dark_hit[gl])
    );
  end

  // Pair permission is symmetric: either half of the matrix grants it.
  logic [N_LIGHTS-1:0][N_LIGHTS-1:0] allowed;
  for (genvar gi = 0; gi < N_LIGHTS; gi++) begin : g_row
    for (genvar gj = 0; gj < N_LIGHTS; gj++) begin : g_col
      assign allowed[gi][gj] = PERMIT[gi*N_LIGHTS+gj] | PERMIT[gj*N_LIGHTS+gi];
    end
  end

  logic [3:0]          conf_cnt;
  logic [N_LIGHTS-1:0] conf_mask;
  logic [N_LIGHTS-1:0] conf_mask_q;
  logic [7:0]          clr_cnt;
  logic [N_LIGHTS-1:0] rel_mask;
  logic [N_LIGHTS-1:0] clr_viol;
  logic [N_LIGHTS-1:0] clr_mask_q;
  logic [N_LIGHTS-1:0] ill_q;
  logic                ack_q;
  logic                all_red_q;

  always_comb begin
    conf_mask = '0;
    clr_viol  = '0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      for (int j = 0; j < N_LIGHTS; j++) begin
        if (i != j && movement[i] && movement[j] && !allowed[i][j]) begin
          conf_mask[i] = 1'b1;
        end
        if (i != j && clr_cnt != 8'd0 && rel_mask[i] && green_rise[j] && !allowed[i][j]) begin
          clr_viol[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_cnt    <= '0;
      conf_mask_q <= '0;
      clr_cnt     <= '0;
      rel_mask    <= '0;
      clr_mask_q  <= '0;
      ill_q       <= '0;
      ack_q       <= 1'b0;
      all_red_q   <= 1'b0;
    end else begin
      if (|conf_mask) begin
        if (conf_cnt != 4'(DEBOUNCE)) begin
          conf_cnt <= conf_cnt + 4'd1;
        end
      end else begin
        conf_cnt <= '0;
      end
      conf_mask_q <= conf_mask;
      // A fresh release restarts the window and names the releasing light(s).
      if (|mov_to_red) begin
        clr_cnt  <= 8'(CLEAR_CYCLES);
        rel_mask <= mov_to_red;
      end else if (clr_cnt != 8'd0) begin
        clr_cnt <= clr_cnt - 8'd1;
      end
      clr_mask_q <= clr_viol;
      ill_q      <= illegal;
      ack_q      <= ack;
      all_red_q  <= &red;
    end
  end

  function automatic logic [1:0] lowest(input logic [N_LIGHTS-1:0] m);
    logic [1:0] idx;
    idx = '0;
    for (int k = N_LIGHTS - 1; k >= 0; k--) begin
      if (m[k]) begin
        idx = 2'(k);
      end
    end
    return idx;
  endfunction

  fault_code_t det_code;
  logic [1:0]  det_light;

  always_comb begin
    det_code  = FC_NONE;
    det_light = '0;
    if (conf_cnt == 4'(DEBOUNCE)) begin
      det_code  = FC_CONFLICT;
      det_light = lowest(conf_mask_q);
    end else if (|clr_mask_q) begin
      det_code  = FC_CLEARANCE;
      det_light = lowest(clr_mask_q);
    end else if (|ill_q) begin
      det_code  = FC_ILLEGAL;
      det_light = lowest(ill_q);
    end else if (|dark_hit) begin
      det_code  = FC_DARK;
      det_light = lowest(dark_hit);
    end
  end

  mon_state_t state;
  logic [7:0] rec_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MONITOR;
      fault       <= 1'b0;
      fault_code  <= '0;
      fault_light <= '0;
      force_reds  <= '0;
      attentions  <= '0;
      rec_cnt     <= '0;
    end else begin
      unique case (state)
        MONITOR: begin
          if (det_code != FC_NONE) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_code  <= det_code;
            fault_light <= det_light;
            force_reds  <= '1;
            attentions  <= '1;
          end
        end
        FAULT: begin
          if (ack_q && all_red_q) begin
            state      <= RECOVER;
            attentions <= '0;
            rec_cnt    <= 8'(CLEAR_CYCLES);
          end
        end
        RECOVER: begin
          // A new fault wins even on the cycle the recovery timer would expire.
          if (det_code != FC_NONE) begin
            state       <= FAULT;
            fault_code  <= det_code;
            fault_light <= det_light;
            attentions  <= '1;
          end else if (rec_cnt <= 8'd1) begin
            state       <= MONITOR;
            fault       <= 1'b0;
            fault_code  <= '0;
            fault_light <= '0;
            force_reds  <= '0;
          end else begin
            rec_cnt <= rec_cnt - 8'd1;
          end
        end
        default: state <= MONITOR;
      endcase
    end
  end

endmodule
